// File: rtl/isp_pkg.sv
// Shared definitions for the in-system programming loader.
// States, frame protocol bytes.
package isp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHK    = 3'd5,
        ST_DRAIN  = 3'd6,
        ST_RESP   = 3'd7
    } isp_state_t;

    localparam logic [7:0] ISP_SYNC = 8'h55;
    localparam logic [7:0] ISP_ACK  = 8'h06;
    localparam logic [7:0] ISP_NAK  = 8'h15;

endpackage

// File: rtl/isp_word_packer.sv
// Byte-to-word packer with running checksum and one-entry skid register.
// Latency: merged byte stream is combinational from rx or skid; word/checksum update on the accepting edge.
// Backpressure: hold_i parks one byte in the skid register; a second held byte sets the sticky overflow flag and is dropped.
module isp_word_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        data_en_i,
    input  logic        rx_dv_i,
    input  logic [7:0]  rx_byte_i,
    output logic        byte_vld_o,
    output logic [7:0]  byte_o,
    output logic [31:0] word_o,
    output logic        last_byte_o,
    output logic [7:0]  csum_o,
    output logic        ovf_o
);

    logic [7:0]  skid_q;
    logic        skid_vld_q;
    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  csum_q;
    logic        ovf_q;

    // Skid byte is older than anything on rx, so it is always presented first.
    assign byte_vld_o  = !hold_i && (skid_vld_q || rx_dv_i);
    assign byte_o      = skid_vld_q ? skid_q : rx_byte_i;
    assign word_o      = {byte_o, word_q[31:8]};
    assign last_byte_o = (byte_cnt_q == 2'd3);
    assign csum_o      = csum_q;
    assign ovf_o       = ovf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            skid_q     <= 8'h00;
            skid_vld_q <= 1'b0;
            word_q     <= 32'h0;
            byte_cnt_q <= 2'd0;
            csum_q     <= 8'h00;
            ovf_q      <= 1'b0;
        end else begin
            if (flush_i) begin
                skid_vld_q <= 1'b0;
            end else if (hold_i) begin
                if (rx_dv_i) begin
                    if (skid_vld_q) begin
                        ovf_q <= 1'b1;
                    end else begin
                        skid_q     <= rx_byte_i;
                        skid_vld_q <= 1'b1;
                    end
                end
            end else if (skid_vld_q) begin
                // Skid drains this cycle; a simultaneous rx byte takes its place.
                if (rx_dv_i) begin
                    skid_q <= rx_byte_i;
                end else begin
                    skid_vld_q <= 1'b0;
                end
            end

            if (data_en_i && byte_vld_o) begin
                word_q     <= word_o;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                csum_q     <= csum_q + byte_o;
            end

            if (clear_i) begin
                byte_cnt_q <= 2'd0;
                csum_q     <= 8'h00;
                ovf_q      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_isp_loader.sv
// ISP loader: frames SPI bytes into words, writes instruction RAM over Wishbone, gates core reset, returns ACK/NAK.
// Latency: write request one cycle after the 4th byte; status byte one cycle after the checksum byte.
// Backpressure: none toward the SPI side; one byte is absorbed while a write is pending, more flags a NAK.
module wb_isp_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 4096,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_dv_i,
    input  logic [7:0]  rx_byte_i,
    output logic        tx_dv_o,
    output logic [7:0]  tx_byte_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        core_rst_no,
    output logic        busy_o,
    output logic        err_o
);

    import isp_pkg::*;

    localparam logic [31:0] GAP_LIMIT = 32'(TIMEOUT_CYC);
    localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

    isp_state_t  state_q, state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] word_cnt_q;
    logic [15:0] word_idx_q;
    logic        fail_q;
    logic [31:0] gap_cnt_q;
    logic        wr_act_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        tx_dv_q;
    logic [7:0]  tx_byte_q;
    logic        core_rst_nq;
    logic        busy_q;
    logic        err_q;

    logic        pk_byte_vld;
    logic [7:0]  pk_byte;
    logic [31:0] pk_word;
    logic        pk_last;
    logic [7:0]  pk_csum;
    logic        pk_ovf;

    logic        sync_hit;
    logic        gap_run;
    logic        gap_expired;
    logic [15:0] len_d;
    logic        resp_go;
    logic        resp_ok;
    logic        wr_start;
    logic        wr_done;

    assign sync_hit    = (state_q == ST_IDLE) && pk_byte_vld && (pk_byte == ISP_SYNC);
    assign gap_run     = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA) ||
                         (state_q == ST_CHK) || (state_q == ST_DRAIN);
    assign gap_expired = (gap_cnt_q == GAP_LIMIT);
    assign len_d       = {pk_byte, len_lo_q};

    isp_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (sync_hit),
        .flush_i     (state_q == ST_RESP),
        .hold_i      (state_q == ST_WRITE),
        .data_en_i   (state_q == ST_DATA),
        .rx_dv_i     (rx_dv_i),
        .rx_byte_i   (rx_byte_i),
        .byte_vld_o  (pk_byte_vld),
        .byte_o      (pk_byte),
        .word_o      (pk_word),
        .last_byte_o (pk_last),
        .csum_o      (pk_csum),
        .ovf_o       (pk_ovf)
    );

    always_comb begin
        state_d  = state_q;
        resp_go  = 1'b0;
        resp_ok  = 1'b0;
        wr_start = 1'b0;
        wr_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_hit) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (pk_byte_vld)      state_d = ST_LEN_HI;
                else if (gap_expired) resp_go = 1'b1;
            end
            ST_LEN_HI: begin
                if (pk_byte_vld) begin
                    if (len_d == 16'h0)              state_d = ST_CHK;
                    else if ({1'b0, len_d} > MAX_N)  state_d = ST_DRAIN;
                    else                             state_d = ST_DATA;
                end else if (gap_expired) begin
                    resp_go = 1'b1;
                end
            end
            ST_DATA: begin
                if (pk_byte_vld) begin
                    if (pk_last) begin
                        state_d  = ST_WRITE;
                        wr_start = 1'b1;
                    end
                end else if (gap_expired) begin
                    resp_go = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wb_ack_i || wb_err_i) begin
                    wr_done = 1'b1;
                    state_d = (word_idx_q + 16'd1 == word_cnt_q) ? ST_CHK : ST_DATA;
                end
            end
            ST_CHK: begin
                if (pk_byte_vld) begin
                    resp_go = 1'b1;
                    resp_ok = (pk_byte == pk_csum) && !fail_q && !pk_ovf;
                end else if (gap_expired) begin
                    resp_go = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (gap_expired) resp_go = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (resp_go) state_d = ST_RESP;
    end

    // Byte-gap counter freezes across a write so slow slaves do not cause a timeout.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gap_cnt_q <= 32'h0;
        end else if (rx_dv_i || !(gap_run || state_q == ST_WRITE)) begin
            gap_cnt_q <= 32'h0;
        end else if (gap_run && !gap_expired) begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= 8'h00;
            word_cnt_q  <= 16'h0;
            word_idx_q  <= 16'h0;
            fail_q      <= 1'b0;
            wr_act_q    <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            sel_q       <= 4'h0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            core_rst_nq <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_dv_q <= resp_go;

            if (sync_hit) begin
                core_rst_nq <= 1'b0;
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
                word_idx_q  <= 16'h0;
                fail_q      <= 1'b0;
            end

            if (state_q == ST_LEN_LO && pk_byte_vld) len_lo_q   <= pk_byte;
            if (state_q == ST_LEN_HI && pk_byte_vld) word_cnt_q <= len_d;

            if (wr_start) begin
                wr_act_q <= 1'b1;
                sel_q    <= 4'hF;
                adr_q    <= BASE_ADDR + {14'h0, word_idx_q, 2'b00};
                dat_q    <= pk_word;
            end

            if (wr_done) begin
                wr_act_q   <= 1'b0;
                sel_q      <= 4'h0;
                word_idx_q <= word_idx_q + 16'd1;
                if (wb_err_i) fail_q <= 1'b1;
            end

            // The core stays held on NAK until a later frame succeeds.
            if (resp_go) begin
                tx_byte_q <= resp_ok ? ISP_ACK : ISP_NAK;
                busy_q    <= 1'b0;
                if (resp_ok) core_rst_nq <= 1'b1;
                else         err_q       <= 1'b1;
            end
        end
    end

    assign tx_dv_o     = tx_dv_q;
    assign tx_byte_o   = tx_byte_q;
    assign wb_cyc_o    = wr_act_q;
    assign wb_stb_o    = wr_act_q;
    assign wb_we_o     = wr_act_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign core_rst_no = core_rst_nq;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: doc/wb_isp_loader.md
# wb_isp_loader

In-system programming loader for the instruction RAM. Consumes the byte stream from the SPI-slave receiver, packs bytes into 32-bit words and writes them into instruction RAM as an extra Wishbone master on the shared bus. Holds the Ibex core in reset for the whole download and releases it after a verified image. Returns a one-byte ACK/NAK status through the SPI-slave transmit path.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first word written (instruction RAM base).
- MAX_WORDS, 4096: largest accepted word count.
- TIMEOUT_CYC, 1_000_000: allowed idle clk_i cycles between bytes inside a frame.
- clk_i  in  1  system clock; the block uses this single clock.
- rst_ni  in  1  reset, synchronous and active-low.
- rx_dv_i  in  1  one-cycle strobe: rx_byte_i is valid.
- rx_byte_i  in  8  received byte.
- tx_dv_o  out  1  one-cycle strobe: tx_byte_o is valid.
- tx_byte_o  out  8  status byte to host.
- wb  master  wishbone_if  classic single-transfer master: cyc, stb, we, adr, dat (out), sel; ack and err (in).
- core_rst_no  out  1  active-low core hold; ANDed with rst_sys_n at the core.
- busy_o  out  1  high while a frame is in progress.
- err_o  out  1  sticky; set on NAK, cleared by the next valid sync byte.

## Operation
- Frame format:
  - sync byte 8'h55;
  - word count N, 16-bit, low byte first;
  - 4·N data bytes, each word little-endian;
  - checksum byte equal to the 8-bit sum mod 256 of all data bytes.
- States (enum in package):
  - IDLE: wait for 8'h55; other bytes are ignored. On sync: core_rst_no←0, busy_o←1, clear err_o, word index and checksum, go to LEN_LO.
  - LEN_LO → LEN_HI: one byte each.
    - After LEN_HI, N=0 goes to CHK.
    - N>MAX_WORDS goes to DRAIN.
    - Otherwise go to DATA.
  - DATA: shift bytes into the word register (byte k → bits 8k+7:8k) and add each to the checksum. The 4th byte goes to WRITE.
  - WRITE: cyc=stb=we=1, sel=4'hF, adr=BASE_ADDR+4·index, dat=word. Hold until ack or err.
    - On ack: index+1; go to CHK if index==N, else DATA.
    - On err: set the internal fail flag and continue as for ack.
  - CHK: receive the checksum byte. ACK when it matches and the fail flag is clear; otherwise NAK. Go to RESP.
  - DRAIN: discard bytes until TIMEOUT_CYC elapse with no byte, then go to RESP with NAK.
  - RESP: pulse tx_dv_o one cycle with 8'h06 (ACK) or 8'h15 (NAK). busy_o←0.
    - On ACK: core_rst_no←1.
    - On NAK: core_rst_no stays 0 and err_o←1. The core is held until a later frame ACKs.
    - Go to IDLE.
- Byte during WRITE: captured in a one-entry skid register and consumed on return to DATA. A second byte while the skid register is full sets the fail flag; that byte is dropped and framing continues.
- Timeout: in LEN_LO, LEN_HI, DATA and CHK, the byte-gap counter reaching TIMEOUT_CYC aborts to RESP with NAK. The counter reloads on every rx_dv_i and does not run during WRITE.
- Checksum and index arithmetic: checksum is 8-bit wrapping; index is 16-bit; address is computed in 32 bits.

## Timing
- Reset values: tx_dv_o=0, tx_byte_o=0, wb cyc/stb/we=0, adr/dat=0, sel=0, core_rst_no=1, busy_o=0, err_o=0, state IDLE.
- Sync byte → core_rst_no low on the next clk_i edge.
- 4th data byte strobe → cyc/stb high the next cycle.
- ack sampled high at an edge → cyc/stb low the next cycle. No back-to-back transfer; at least one idle cycle between writes.
- Checksum byte strobe → RESP the next cycle; tx_dv_o high for exactly one cycle. core_rst_no rises in the same cycle as tx_dv_o on ACK.
- Reset mid-frame: WRITE is abandoned immediately (cyc drops) and all state returns to reset values. RAM contents are left partial.
- rx_dv_i in the same cycle as ack: the byte goes to the skid register; no loss.

## Structure
- isp_pkg holds:
  - the state enum;
  - ISP_SYNC=8'h55, ISP_ACK=8'h06, ISP_NAK=8'h15.
- One sub-module: isp_word_packer (byte shift, checksum, skid register, overflow flag). The FSM, Wishbone master and timeout counter live in wb_isp_loader.

## Test plan
- Frame 55 02 00, then bytes 13 00 00 00 and 6F 00 00 00, checksum 0x82:
  - writes 0x00000013 @0x0 and 0x0000006F @0x4, sel=F;
  - tx 0x06; core_rst_no 0→1.
- Same frame with checksum 0x83: both writes occur; tx 0x15; err_o=1; core_rst_no stays 0.
- Frame with N=0 and checksum 00: no Wishbone cycle; tx 0x06.
- N=0x1001 with MAX_WORDS=4096: DRAIN; after the byte gap exceeds TIMEOUT_CYC, tx 0x15.
- Slave ack delayed 20 cycles while the next byte arrives: skid holds the byte and data is correct; a second early byte gives NAK.
- rst_ni low while cyc=1: cyc=0 the next cycle; core_rst_no=1; busy_o=0.
